// File: rtl/delay_pkg.sv
// Shared constants, word type and parameter check for the fixed-latency delay line.
package delay_pkg;

   localparam int DELAY_DEFAULT_WIDTH = 4;
   localparam int DELAY_DEFAULT_DEPTH = 3;
   localparam int DELAY_MAX_DEPTH     = 64;

   // Word type at the default width; instances with other widths declare
   // the matching logic [WIDTH-1:0] locally.
   typedef logic [DELAY_DEFAULT_WIDTH-1:0] delay_word_t;

   function automatic bit delay_depth_ok(input int depth);
      return (depth >= 1) && (depth <= DELAY_MAX_DEPTH);
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One WIDTH-bit pipeline register that clears to zero on a synchronous reset.
module delay_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/delay.sv
// Fixed-latency delay line: b is a delayed by exactly DEPTH rising edges.
module delay
   import delay_pkg::*;
#(
   parameter int WIDTH = DELAY_DEFAULT_WIDTH,
   parameter int DEPTH = DELAY_DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   localparam type word_t = logic [WIDTH-1:0];

   if (!delay_depth_ok(DEPTH)) begin : g_bad_depth
      $error("delay: DEPTH must be in 1..64");
   end

   word_t stage_q [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      word_t stage_d;

      if (gi == 0) begin : g_head
         assign stage_d = a;
      end else begin : g_link
         assign stage_d = stage_q[gi-1];
      end

      delay_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk (clk),
         .rst (rst),
         .d_i (stage_d),
         .q_o (stage_q[gi])
      );
   end

   // Output is taken straight from the last flop.
   assign b = stage_q[DEPTH-1];

endmodule

// File: tb/tb_delay.sv
// Directed vector bench for delay (DEPTH=3/WIDTH=4) plus a DEPTH=1/WIDTH=8 instance.
module tb_delay;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] a1;
   logic [7:0] b1;

   int total;
   int bad;

   typedef struct {
      logic       rst;
      logic [3:0] a;
      logic [3:0] exp_b;
      string      name;
   } vec_t;

   vec_t vecs[$];

   delay #(.WIDTH(4), .DEPTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b)
   );

   delay #(.WIDTH(8), .DEPTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .a   (a1),
      .b   (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] av, input logic [3:0] eb, input string nm);
      vec_t v;
      v.rst   = r;
      v.a     = av;
      v.exp_b = eb;
      v.name  = nm;
      vecs.push_back(v);
   endtask

   task automatic check4(input string nm, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: b=%h expected %h", nm, got, exp);
      end else begin
         $display("ok   %s: b=%h", nm, got);
      end
   endtask

   task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: b=%h expected %h", nm, got, exp);
      end else begin
         $display("ok   %s: b=%h", nm, got);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a     = 4'bx;
      a1    = 8'h00;

      // Expected b is the value just after the edge that samples the row's inputs.
      add(1'b1, 4'bx,    4'h0, "reset0");
      add(1'b1, 4'bx,    4'h0, "reset1");
      add(1'b0, 4'h1,    4'h0, "ramp_a1");
      add(1'b0, 4'h2,    4'h0, "ramp_a2");
      add(1'b0, 4'h3,    4'h1, "ramp_a3");
      add(1'b0, 4'h4,    4'h2, "ramp_a4");
      add(1'b0, 4'h5,    4'h3, "ramp_a5");
      add(1'b1, 4'h6,    4'h0, "mid_rst_a6");
      add(1'b0, 4'h7,    4'h0, "post_rst_a7");
      add(1'b0, 4'h8,    4'h0, "post_rst_a8");
      add(1'b0, 4'h9,    4'h7, "post_rst_a9");
      add(1'b0, 4'hF,    4'h8, "width_F0");
      add(1'b0, 4'h0,    4'h9, "width_00");
      add(1'b0, 4'hF,    4'hF, "width_F1");
      add(1'b0, 4'h0,    4'h0, "width_01");
      add(1'b0, 4'hF,    4'hF, "width_F2");
      add(1'b0, 4'h0,    4'h0, "width_02");
      add(1'b1, 4'h0,    4'h0, "hold_rst");
      for (int i = 0; i < 10; i++) begin
         add(1'b0, 4'h9, (i < 2) ? 4'h0 : 4'h9, $sformatf("hold_%0d", i));
      end
      add(1'b0, 4'bx,    4'h9, "xprop_0");
      add(1'b0, 4'h5,    4'h9, "xprop_1");
      add(1'b0, 4'h5,    4'bx, "xprop_2");
      add(1'b0, 4'h5,    4'h5, "xprop_3");

      @(negedge clk);
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         a   = vecs[i].a;
         @(posedge clk);
         @(negedge clk);
         check4(vecs[i].name, b, vecs[i].exp_b);
      end

      // DEPTH=1 instance: reset clears, then one-edge latency.
      rst = 1'b1;
      a1  = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      check8("d1_reset", b1, 8'h00);
      rst = 1'b0;
      a1  = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      check8("d1_A5", b1, 8'hA5);
      a1 = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      check8("d1_5A", b1, 8'h5A);
      a1 = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      check8("d1_3C", b1, 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
